// File: rtl/flash_cmd_sequencer.sv
// flash_cmd_sequencer: JEDEC command-cycle sequencer for the cartridge PRG flash
// Ports:
//   m2, rst_n                 clock, asynchronous active-low reset
//   req, cmd, addr, wdata     start strobe (sampled in IDLE), command, target address, program data
//   flash_din                 flash read-back used for toggle-bit polling
//   busy, done, error         operation in progress, one-clock completion pulse, result flag
//   bus_own                   sequencer owns the flash bus (flash_* replace the CPU path)
//   flash_addr, flash_dout    flash address and write data
//   flash_we_n, flash_oe_n    flash write / output enables, active low
module flash_cmd_sequencer #(
  parameter int          ADDR_W     = 27,
  parameter logic [11:0] UNLOCK_A   = 12'hAAA,
  parameter logic [11:0] UNLOCK_B   = 12'h555,
  parameter logic [15:0] POLL_LIMIT = 16'hFFFF
) (
  input  logic              m2,
  input  logic              rst_n,
  input  logic              req,
  input  logic [1:0]        cmd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  input  logic [7:0]        flash_din,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              bus_own,
  output logic [ADDR_W-1:0] flash_addr,
  output logic [7:0]        flash_dout,
  output logic              flash_we_n,
  output logic              flash_oe_n
);
  typedef enum logic [3:0] {
    IDLE, WR_SETUP, WR_STROBE, WR_HOLD, POLL_A, POLL_B, POLL_GAP, ABORT, DONE
  } state_t;
  state_t state_q, state_d;
  logic [1:0]        cmd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wdata_q;
  logic [2:0]        idx_q;
  logic [15:0]       cnt_q, cnt_nxt;
  logic              extra_q, abort_q, error_q, t0_q;
  logic [1:0]        t1_q;
  logic [1:0]        asel;
  logic [7:0]        cyc_data;
  logic [ADDR_W-1:0] cyc_addr;
  logic              last, toggled, wr, unused_din;
  assign unused_din = ^{flash_din[7], flash_din[4:0]};
  always_comb begin
    asel = 2'd0;
    cyc_data = 8'hF0;
    case (idx_q)
      3'd0: begin asel = 2'd1; cyc_data = 8'hAA; end
      3'd1: begin asel = 2'd2; cyc_data = 8'h55; end
      3'd2: begin asel = 2'd1; cyc_data = cmd_q == 2'b00 ? 8'hA0 : 8'h80; end
      3'd3: begin asel = cmd_q == 2'b00 ? 2'd0 : 2'd1; cyc_data = cmd_q == 2'b00 ? wdata_q : 8'hAA; end
      3'd4: begin asel = 2'd2; cyc_data = 8'h55; end
      default: begin asel = cmd_q == 2'b10 ? 2'd1 : 2'd0; cyc_data = cmd_q == 2'b10 ? 8'h10 : 8'h30; end
    endcase
    // the reset command and the abort cycle are a single F0 write at the target address
    if (abort_q || cmd_q == 2'b11) begin
      asel = 2'd0;
      cyc_data = 8'hF0;
    end
  end
  assign cyc_addr = asel == 2'd1 ? {addr_q[ADDR_W-1:12], UNLOCK_A} :
                    asel == 2'd2 ? {addr_q[ADDR_W-1:12], UNLOCK_B} : addr_q;
  assign last     = abort_q || cmd_q == 2'b11 || (cmd_q == 2'b00 && idx_q == 3'd3) || idx_q == 3'd5;
  assign toggled  = t0_q != t1_q[1];
  assign cnt_nxt  = cnt_q == POLL_LIMIT ? cnt_q : cnt_q + 16'd1;
  always_ff @(posedge m2 or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = req ? WR_SETUP : IDLE;
      WR_SETUP:  state_d = WR_STROBE;
      ABORT:     state_d = WR_STROBE;
      WR_STROBE: state_d = WR_HOLD;
      WR_HOLD:   state_d = !last ? WR_SETUP : (abort_q || cmd_q == 2'b11) ? DONE : POLL_A;
      POLL_A:    state_d = POLL_B;
      POLL_B:    state_d = POLL_GAP;
      // DQ5 grants exactly one confirmation pair; otherwise the counter bounds the wait
      POLL_GAP:  state_d = !toggled ? DONE : extra_q ? ABORT : t1_q[0] ? POLL_A :
                           cnt_nxt == POLL_LIMIT ? ABORT : POLL_A;
      default:   state_d = IDLE;
    endcase
  end
  always_ff @(posedge m2 or negedge rst_n)
    if (!rst_n) begin
      cmd_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      extra_q <= 1'b0;
      abort_q <= 1'b0;
      error_q <= 1'b0;
      t0_q    <= 1'b0;
      t1_q    <= '0;
    end else begin
      if (state_q == IDLE && req) begin
        cmd_q   <= cmd;
        addr_q  <= addr;
        wdata_q <= wdata;
        idx_q   <= '0;
        cnt_q   <= '0;
        extra_q <= 1'b0;
        abort_q <= 1'b0;
        error_q <= 1'b0;
      end
      if (state_q == WR_HOLD && !last) idx_q <= idx_q + 3'd1;
      if (state_q == POLL_A) t0_q <= flash_din[6];
      if (state_q == POLL_B) t1_q <= flash_din[6:5];
      if (state_q == POLL_GAP && toggled && !extra_q) begin
        if (t1_q[0]) extra_q <= 1'b1;
        else cnt_q <= cnt_nxt;
      end
      if (state_d == ABORT) begin
        abort_q <= 1'b1;
        error_q <= 1'b1;
      end
    end
  always_comb begin
    wr         = state_q inside {WR_SETUP, WR_STROBE, WR_HOLD, ABORT};
    busy       = state_q != IDLE;
    bus_own    = state_q != IDLE;
    done       = state_q == DONE;
    error      = error_q;
    flash_we_n = state_q != WR_STROBE;
    flash_oe_n = !(state_q == POLL_A || state_q == POLL_B);
    flash_addr = state_q == IDLE ? '0 : wr ? cyc_addr : addr_q;
    flash_dout = wr ? cyc_data : 8'h00;
  end
endmodule

// File: tb/tb_flash_cmd_sequencer.sv
// tb_flash_cmd_sequencer: directed scoreboard bench for flash_cmd_sequencer
module tb_flash_cmd_sequencer;
  logic        m2 = 1'b0, rst_n = 1'b0, req = 1'b0, sel = 1'b0;
  logic [1:0]  cmd = '0, mode = '0;
  logic [26:0] addr = '0;
  logic [7:0]  wdata = '0, din0, din1;
  logic        busy0, done0, err0, own0, we0, oe0, busy1, done1, err1, own1, we1, oe1;
  logic [26:0] fa0, fa1;
  logic [7:0]  fd0, fd1;
  logic        busy_s, done_s, err_s, own_s, we_s, oe_s;
  logic [26:0] fa_s;
  logic [7:0]  fd_s;
  logic [34:0] sb[$];
  int          n_cmp = 0, n_err = 0, rd0 = 0, rd1 = 0, base0 = 0, oe_lo = 0;

  always #5 m2 = ~m2;

  flash_cmd_sequencer u0 (
    .m2(m2), .rst_n(rst_n), .req(req && !sel), .cmd(cmd), .addr(addr), .wdata(wdata),
    .flash_din(din0), .busy(busy0), .done(done0), .error(err0), .bus_own(own0),
    .flash_addr(fa0), .flash_dout(fd0), .flash_we_n(we0), .flash_oe_n(oe0)
  );
  flash_cmd_sequencer #(.POLL_LIMIT(16'd4)) u1 (
    .m2(m2), .rst_n(rst_n), .req(req && sel), .cmd(cmd), .addr(addr), .wdata(wdata),
    .flash_din(din1), .busy(busy1), .done(done1), .error(err1), .bus_own(own1),
    .flash_addr(fa1), .flash_dout(fd1), .flash_we_n(we1), .flash_oe_n(oe1)
  );

  assign busy_s = sel ? busy1 : busy0;
  assign done_s = sel ? done1 : done0;
  assign err_s  = sel ? err1 : err0;
  assign own_s  = sel ? own1 : own0;
  assign we_s   = sel ? we1 : we0;
  assign oe_s   = sel ? oe1 : oe0;
  assign fa_s   = sel ? fa1 : fa0;
  assign fd_s   = sel ? fd1 : fd0;

  // flash model: DQ6 flips on every read while "busy"; mode 0 ready (0xFF),
  // mode 1 busy for 20 reads, mode 2 busy forever with DQ5 set
  always @(posedge m2) begin
    if (!oe0) rd0 <= rd0 + 1;
    if (!oe1) rd1 <= rd1 + 1;
  end
  always_comb begin
    din0 = 8'hFF;
    if (mode == 2'd1) din0 = (rd0 - base0 < 20) ? {1'b0, rd0[0], 6'b0} : 8'h40;
    if (mode == 2'd2) din0 = {1'b0, rd0[0], 1'b1, 5'b0};
    din1 = {1'b0, rd1[0], 6'b0};
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge m2) begin
    chk("we_oe_exclusive", 64'(we_s | oe_s), 64'd1);
    if (!oe_s) oe_lo++;
    if (!we_s) begin
      chk("we_expected", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) chk("we_cycle", 64'({fa_s, fd_s}), 64'(sb.pop_front()));
    end
  end

  task automatic push(input logic [26:0] a, input logic [7:0] d);
    sb.push_back({a, d});
  endtask
  task automatic push_u(input logic [26:0] a, input logic [11:0] lo, input logic [7:0] d);
    sb.push_back({a[26:12], lo, d});
  endtask
  task automatic exp_prog(input logic [26:0] a, input logic [7:0] d);
    push_u(a, 12'hAAA, 8'hAA); push_u(a, 12'h555, 8'h55); push_u(a, 12'hAAA, 8'hA0); push(a, d);
  endtask
  task automatic exp_erase(input logic [26:0] a, input bit chip);
    push_u(a, 12'hAAA, 8'hAA); push_u(a, 12'h555, 8'h55); push_u(a, 12'hAAA, 8'h80);
    push_u(a, 12'hAAA, 8'hAA); push_u(a, 12'h555, 8'h55);
    if (chip) push_u(a, 12'hAAA, 8'h10);
    else push(a, 8'h30);
  endtask

  // k counts edges after the accepting edge until done is seen (spec latency minus 2)
  task automatic run(input string tag, input logic s, input logic [1:0] c, input logic [26:0] a,
                     input logic [7:0] d, input int exp_k, input logic exp_err,
                     input int exp_pairs, input bit inject);
    int k;
    @(negedge m2);
    sel = s; cmd = c; addr = a; wdata = d; req = 1'b1; oe_lo = 0; base0 = rd0;
    @(posedge m2);
    #1 req = 1'b0;
    k = 0;
    @(negedge m2);
    while (!done_s && k < 400) begin
      if (inject && k == 5) begin req = 1'b1; cmd = 2'b11; addr = 27'h7FFFFFF; end
      if (inject && k == 6) req = 1'b0;
      k++;
      @(negedge m2);
    end
    chk({tag, "_latency"}, 64'(k), 64'(exp_k));
    chk({tag, "_error"}, 64'(err_s), 64'(exp_err));
    chk({tag, "_poll_pairs"}, 64'(oe_lo / 2), 64'(exp_pairs));
    @(negedge m2);
    chk({tag, "_done_pulse"}, 64'({done_s, busy_s, own_s}), 64'd0);
    chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_flags"}, 64'({busy_s, done_s, err_s, own_s}), 64'd0);
    chk({tag, "_enables"}, 64'({we_s, oe_s}), 64'd3);
    chk({tag, "_addr_data"}, 64'({fa_s, fd_s}), 64'd0);
  endtask

  initial begin
    #2 chk_reset("por");
    @(negedge m2) rst_n = 1'b1;
    exp_prog(27'h0123456, 8'h5A);
    run("program", 1'b0, 2'b00, 27'h0123456, 8'h5A, 15, 1'b0, 1, 1'b0);
    push(27'h0000321, 8'hF0);
    run("reset_cmd", 1'b0, 2'b11, 27'h0000321, 8'h00, 3, 1'b0, 0, 1'b0);
    mode = 2'd1;
    exp_erase(27'h0010000, 1'b0);
    run("sector_erase", 1'b0, 2'b01, 27'h0010000, 8'h00, 51, 1'b0, 11, 1'b0);
    mode = 2'd0;
    exp_erase(27'h7ABC123, 1'b1);
    run("chip_erase", 1'b0, 2'b10, 27'h7ABC123, 8'h00, 21, 1'b0, 1, 1'b0);
    mode = 2'd2;
    exp_prog(27'h0055000, 8'hC3); push(27'h0055000, 8'hF0);
    run("dq5_fail", 1'b0, 2'b00, 27'h0055000, 8'hC3, 21, 1'b1, 2, 1'b0);
    mode = 2'd0;
    exp_prog(27'h0300010, 8'h99); push(27'h0300010, 8'hF0);
    run("timeout", 1'b1, 2'b00, 27'h0300010, 8'h99, 27, 1'b1, 4, 1'b0);
    @(negedge m2);
    sel = 1'b0; cmd = 2'b00; addr = 27'h0222222; wdata = 8'h11; req = 1'b1;
    push_u(27'h0222222, 12'hAAA, 8'hAA);
    @(posedge m2);
    #1 req = 1'b0;
    repeat (4) @(posedge m2);
    #1 chk("mid_strobe", 64'({we_s, fa_s, fd_s}), 64'({1'b0, 27'h0222555, 8'h55}));
    rst_n = 1'b0;
    #1 chk_reset("mid_reset");
    chk("mid_reset_sb", 64'(sb.size()), 64'd0);
    @(negedge m2) rst_n = 1'b1;
    exp_prog(27'h0444444, 8'h3C);
    run("busy_req", 1'b0, 2'b00, 27'h0444444, 8'h3C, 15, 1'b0, 1, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
